// File: rtl/counter_csr_unit_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | counter_csr_unit_pkg                                              |
// | CSR addresses and mcountinhibit layout shared by the counter CSRs |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package counter_csr_unit_pkg;

  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

  localparam int          MCI_IR_BIT   = 2;
  localparam logic [63:0] TIMECMP_RST  = 64'hFFFF_FFFF_FFFF_FFFF;

  // Only IR is implemented; every other mcountinhibit bit reads zero.
  function automatic logic [31:0] mci_read(input logic ir);
    logic [31:0] v;
    v             = '0;
    v[MCI_IR_BIT] = ir;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter_csr_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | counter_csr_unit_if                                               |
// | CSR access-stage request/response bus                             |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface counter_csr_unit_if;

  logic        CSR_RE_IP;
  logic        CSR_WE_IP;
  logic [11:0] CSR_ADDR_IP;
  logic [31:0] CSR_WDATA_IP;
  logic [31:0] CSR_RDATA_OP;
  logic        CSR_RVALID_OP;
  logic        CSR_ILLEGAL_OP;

  modport slave (
    input  CSR_RE_IP, CSR_WE_IP, CSR_ADDR_IP, CSR_WDATA_IP,
    output CSR_RDATA_OP, CSR_RVALID_OP, CSR_ILLEGAL_OP
  );

  modport master (
    output CSR_RE_IP, CSR_WE_IP, CSR_ADDR_IP, CSR_WDATA_IP,
    input  CSR_RDATA_OP, CSR_RVALID_OP, CSR_ILLEGAL_OP
  );

endinterface
`default_nettype wire

// File: rtl/counter_csr_unit_counter64_ext.sv
`default_nettype none
// +------------------------------------------------------------------+
// | counter64_ext                                                     |
// | Extends the free-running 32-bit cycle count to 64 bits            |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module counter64_ext (
  input  logic        CLK_IP,
  input  logic        RSTN_IP,
  input  logic [31:0] counter_i,
  input  logic        hi_we_i,
  input  logic [31:0] hi_wdata_i,
  output logic [31:0] cycle_hi_o
);

  logic [31:0] prev_lo_q;
  logic [31:0] cycle_hi_q;
  logic [31:0] cycle_hi_d;
  logic        wrap;

  assign wrap = (counter_i < prev_lo_q);

  // A software write to the high half takes precedence over a same-cycle wrap.
  always_comb begin
    cycle_hi_d = cycle_hi_q;
    if (hi_we_i) begin
      cycle_hi_d = hi_wdata_i;
    end else if (wrap) begin
      cycle_hi_d = cycle_hi_q + 32'd1;
    end
  end

  always_ff @(posedge CLK_IP or negedge RSTN_IP) begin
    if (!RSTN_IP) begin
      prev_lo_q  <= '0;
      cycle_hi_q <= '0;
    end else begin
      prev_lo_q  <= counter_i;
      cycle_hi_q <= cycle_hi_d;
    end
  end

  assign cycle_hi_o = cycle_hi_q;

endmodule
`default_nettype wire

// File: rtl/counter_csr_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | counter_csr_unit                                                  |
// | Zicntr/machine counter CSRs, mcountinhibit and timer compare      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module counter_csr_unit
  import counter_csr_unit_pkg::*;
#(
  parameter bit          INSTRET_EN   = 1'b1,
  parameter logic [11:0] TIMECMP_BASE = 12'h7C0
) (
  input  logic              CLK_IP,
  input  logic              RSTN_IP,
  input  logic [31:0]       COUNTER_IP,
  input  logic              RETIRE_IP,
  counter_csr_unit_if.slave csr_io,
  output logic              TIMER_IRQ_OP
);

  localparam logic [11:0] TIMECMPH_ADDR = TIMECMP_BASE + 12'd1;

  logic [11:0] addr;
  logic [31:0] wdata;
  logic        req;
  logic        hit;
  logic        writable;
  logic        illegal;
  logic        wr_en;
  logic [31:0] rval;

  logic [31:0] cycle_hi;
  logic [63:0] cycle64;
  logic [63:0] minstret_q;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        mci_ir_q, mci_ir_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        illegal_q, illegal_d;
  logic        irq_q, irq_d;

  assign addr    = csr_io.CSR_ADDR_IP;
  assign wdata   = csr_io.CSR_WDATA_IP;
  assign req     = csr_io.CSR_RE_IP | csr_io.CSR_WE_IP;
  assign illegal = req & (~hit | (csr_io.CSR_WE_IP & ~writable));
  assign wr_en   = csr_io.CSR_WE_IP & hit & writable;
  assign cycle64 = {cycle_hi, COUNTER_IP};

  counter64_ext u_counter64_ext (
    .CLK_IP     (CLK_IP),
    .RSTN_IP    (RSTN_IP),
    .counter_i  (COUNTER_IP),
    .hi_we_i    (wr_en && (addr == CSR_MCYCLEH)),
    .hi_wdata_i (wdata),
    .cycle_hi_o (cycle_hi)
  );

  always_comb begin
    hit      = 1'b1;
    writable = 1'b1;
    rval     = '0;
    case (addr)
      CSR_CYCLE:         begin rval = COUNTER_IP;        writable = 1'b0; end
      CSR_MCYCLE:        begin rval = COUNTER_IP;        writable = 1'b0; end
      CSR_CYCLEH:        begin rval = cycle_hi;          writable = 1'b0; end
      CSR_MCYCLEH:             rval = cycle_hi;
      CSR_INSTRET:       begin rval = minstret_q[31:0];  writable = 1'b0; end
      CSR_INSTRETH:      begin rval = minstret_q[63:32]; writable = 1'b0; end
      CSR_MINSTRET:            rval = minstret_q[31:0];
      CSR_MINSTRETH:           rval = minstret_q[63:32];
      CSR_MCOUNTINHIBIT:       rval = mci_read(mci_ir_q);
      TIMECMP_BASE:            rval = mtimecmp_q[31:0];
      TIMECMPH_ADDR:           rval = mtimecmp_q[63:32];
      default:                 hit  = 1'b0;
    endcase
  end

  generate
    if (INSTRET_EN) begin : g_instret
      logic [63:0] minstret_d;

      // A write to either half wins over a same-cycle retire.
      always_comb begin
        minstret_d = minstret_q;
        if (wr_en && (addr == CSR_MINSTRET)) begin
          minstret_d[31:0] = wdata;
        end else if (wr_en && (addr == CSR_MINSTRETH)) begin
          minstret_d[63:32] = wdata;
        end else if (RETIRE_IP && !mci_ir_q) begin
          minstret_d = minstret_q + 64'd1;
        end
      end

      always_ff @(posedge CLK_IP or negedge RSTN_IP) begin
        if (!RSTN_IP) begin
          minstret_q <= '0;
        end else begin
          minstret_q <= minstret_d;
        end
      end
    end else begin : g_no_instret
      assign minstret_q = '0;
    end
  endgenerate

  always_comb begin
    mci_ir_d   = mci_ir_q;
    mtimecmp_d = mtimecmp_q;
    if (wr_en) begin
      if (addr == CSR_MCOUNTINHIBIT) mci_ir_d          = wdata[MCI_IR_BIT];
      if (addr == TIMECMP_BASE)      mtimecmp_d[31:0]  = wdata;
      if (addr == TIMECMPH_ADDR)     mtimecmp_d[63:32] = wdata;
    end
    rvalid_d  = req;
    illegal_d = illegal;
    rdata_d   = rdata_q;
    if (req) begin
      rdata_d = illegal ? 32'd0 : rval;
    end
    irq_d = (cycle64 >= mtimecmp_q);
  end

  always_ff @(posedge CLK_IP or negedge RSTN_IP) begin
    if (!RSTN_IP) begin
      mci_ir_q   <= 1'b0;
      mtimecmp_q <= TIMECMP_RST;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      illegal_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      mci_ir_q   <= mci_ir_d;
      mtimecmp_q <= mtimecmp_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      illegal_q  <= illegal_d;
      irq_q      <= irq_d;
    end
  end

  assign csr_io.CSR_RDATA_OP   = rdata_q;
  assign csr_io.CSR_RVALID_OP  = rvalid_q;
  assign csr_io.CSR_ILLEGAL_OP = illegal_q;
  assign TIMER_IRQ_OP          = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_csr_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_counter_csr_unit                                               |
// | Directed and randomized checks against a 64-bit counter model     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_counter_csr_unit;

  logic        CLK_IP = 1'b0;
  logic        RSTN_IP;
  logic [31:0] COUNTER_IP;
  logic        RETIRE_IP;
  logic        irq;

  counter_csr_unit_if bus ();

  counter_csr_unit dut (
    .CLK_IP       (CLK_IP),
    .RSTN_IP      (RSTN_IP),
    .COUNTER_IP   (COUNTER_IP),
    .RETIRE_IP    (RETIRE_IP),
    .csr_io       (bus),
    .TIMER_IRQ_OP (irq)
  );

  always #5 CLK_IP = ~CLK_IP;

  int checks   = 0;
  int failures = 0;

  // Architectural model state
  logic [31:0] m_hi, m_prev, m_rdata;
  logic [63:0] m_instret, m_cmp;
  logic        m_ir;
  logic        exp_rvalid, exp_ill, exp_irq;
  logic [31:0] exp_rdata;

  task automatic model_reset();
    m_hi = 0; m_prev = 0; m_instret = 0; m_ir = 0;
    m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_rdata = 0;
  endtask

  // Predict the response to the inputs currently presented, then advance.
  task automatic model_step();
    logic        req, hit, wable, ill, we, wr;
    logic [31:0] val, wd;
    logic [11:0] a;
    a = bus.CSR_ADDR_IP; wd = bus.CSR_WDATA_IP; we = bus.CSR_WE_IP;
    req = bus.CSR_RE_IP | we;
    hit = 1; wable = 1; val = 0;
    case (a)
      12'hC00, 12'hB00: begin val = COUNTER_IP; wable = (a == 12'hB00) ? 1'b0 : 1'b0; end
      12'hC80: begin val = m_hi; wable = 0; end
      12'hB80: val = m_hi;
      12'hC02: begin val = m_instret[31:0]; wable = 0; end
      12'hC82: begin val = m_instret[63:32]; wable = 0; end
      12'hB02: val = m_instret[31:0];
      12'hB82: val = m_instret[63:32];
      12'h320: val = m_ir ? 32'd4 : 32'd0;
      12'h7C0: val = m_cmp[31:0];
      12'h7C1: val = m_cmp[63:32];
      default: hit = 0;
    endcase
    ill = req && (!hit || (we && !wable));
    wr  = req && we && !ill;
    exp_rvalid = req;
    exp_ill    = ill;
    if (req) m_rdata = ill ? 32'd0 : val;
    exp_rdata = m_rdata;
    exp_irq   = ({m_hi, COUNTER_IP} >= m_cmp);
    if (wr && a == 12'hB80) m_hi = wd;
    else if (COUNTER_IP < m_prev) m_hi = m_hi + 1;
    m_prev = COUNTER_IP;
    if (wr && a == 12'hB02) m_instret[31:0] = wd;
    else if (wr && a == 12'hB82) m_instret[63:32] = wd;
    else if (RETIRE_IP && !m_ir) m_instret = m_instret + 1;
    if (wr && a == 12'h320) m_ir = wd[2];
    if (wr && a == 12'h7C0) m_cmp[31:0] = wd;
    if (wr && a == 12'h7C1) m_cmp[63:32] = wd;
  endtask

  task automatic step();
    model_step();
    @(posedge CLK_IP);
    #1;
  endtask

  task automatic drive(input logic re, input logic we, input logic [11:0] a, input logic [31:0] d);
    bus.CSR_RE_IP = re; bus.CSR_WE_IP = we; bus.CSR_ADDR_IP = a; bus.CSR_WDATA_IP = d;
  endtask

  task automatic test_reset();
    RSTN_IP = 0; COUNTER_IP = 0; RETIRE_IP = 0;
    drive(0, 0, 12'h000, 0);
    model_reset();
    repeat (2) @(posedge CLK_IP);
    #1;
    checks += 4;
    if (bus.CSR_RDATA_OP !== 32'd0) begin failures++; $display("FAIL reset_rdata got %h want 0", bus.CSR_RDATA_OP); end
    if (bus.CSR_RVALID_OP !== 1'b0) begin failures++; $display("FAIL reset_rvalid got %b want 0", bus.CSR_RVALID_OP); end
    if (bus.CSR_ILLEGAL_OP !== 1'b0) begin failures++; $display("FAIL reset_illegal got %b want 0", bus.CSR_ILLEGAL_OP); end
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got %b want 0", irq); end
    RSTN_IP = 1;
    COUNTER_IP = 5;
    drive(1, 0, 12'hC00, 0);
    step();
    checks += 4;
    if (bus.CSR_RVALID_OP !== 1'b1) begin failures++; $display("FAIL read_cycle_rvalid got %b want 1", bus.CSR_RVALID_OP); end
    if (bus.CSR_RDATA_OP !== 32'd5) begin failures++; $display("FAIL read_cycle_rdata got %h want 5", bus.CSR_RDATA_OP); end
    if (bus.CSR_ILLEGAL_OP !== 1'b0) begin failures++; $display("FAIL read_cycle_illegal got %b want 0", bus.CSR_ILLEGAL_OP); end
    if (irq !== 1'b0) begin failures++; $display("FAIL read_cycle_irq got %b want 0", irq); end
    drive(0, 0, 12'h000, 0);
    step();
    checks++;
    if (bus.CSR_RVALID_OP !== 1'b0 || bus.CSR_RDATA_OP !== 32'd5) begin
      failures++; $display("FAIL idle_hold got v=%b d=%h want v=0 d=5", bus.CSR_RVALID_OP, bus.CSR_RDATA_OP);
    end
  endtask

  task automatic test_wrap();
    COUNTER_IP = 32'hFFFF_FFFE; step();
    COUNTER_IP = 32'hFFFF_FFFF; drive(1, 0, 12'hC80, 0); step();
    checks++;
    if (bus.CSR_RDATA_OP !== 32'd0) begin failures++; $display("FAIL cycleh_prewrap got %h want 0", bus.CSR_RDATA_OP); end
    COUNTER_IP = 32'h0; step();
    checks++;
    if (bus.CSR_RDATA_OP !== 32'd0) begin failures++; $display("FAIL cycleh_wrap_edge got %h want 0", bus.CSR_RDATA_OP); end
    COUNTER_IP = 32'h1; step();
    checks++;
    if (bus.CSR_RDATA_OP !== 32'd1) begin failures++; $display("FAIL cycleh_postwrap got %h want 1", bus.CSR_RDATA_OP); end
    drive(0, 0, 12'h000, 0);
  endtask

  task automatic test_instret();
    RETIRE_IP = 1;
    repeat (10) step();
    RETIRE_IP = 0;
    drive(0, 1, 12'h320, 32'd4); step();
    drive(0, 0, 12'h000, 0); RETIRE_IP = 1;
    repeat (3) step();
    RETIRE_IP = 0;
    drive(1, 0, 12'h320, 0); step();
    checks++;
    if (bus.CSR_RDATA_OP !== 32'd4) begin failures++; $display("FAIL mcountinhibit_read got %h want 4", bus.CSR_RDATA_OP); end
    drive(1, 0, 12'hB02, 0); step();
    checks++;
    if (bus.CSR_RDATA_OP !== 32'd10) begin failures++; $display("FAIL minstret_inhibit got %h want 10", bus.CSR_RDATA_OP); end
    drive(0, 1, 12'h320, 32'd0); step();
    drive(1, 1, 12'hB02, 32'hFFFF_FFFF); RETIRE_IP = 1; step();
    checks++;
    if (bus.CSR_RDATA_OP !== 32'd10) begin failures++; $display("FAIL minstret_rw_old got %h want 10", bus.CSR_RDATA_OP); end
    RETIRE_IP = 0;
    drive(1, 0, 12'hB02, 0); step();
    checks++;
    if (bus.CSR_RDATA_OP !== 32'hFFFF_FFFF) begin failures++; $display("FAIL minstret_write_wins got %h want ffffffff", bus.CSR_RDATA_OP); end
    drive(1, 0, 12'hC82, 0); step();
    checks++;
    if (bus.CSR_RDATA_OP !== 32'd0) begin failures++; $display("FAIL instreth got %h want 0", bus.CSR_RDATA_OP); end
    drive(0, 0, 12'h000, 0);
  endtask

  task automatic test_illegal();
    logic [11:0] addrs [3];
    logic        wes   [3];
    addrs[0] = 12'hB00; wes[0] = 1;
    addrs[1] = 12'hC02; wes[1] = 1;
    addrs[2] = 12'h123; wes[2] = 0;
    for (int i = 0; i < 3; i++) begin
      drive(!wes[i], wes[i], addrs[i], 32'h1234_5678); step();
      checks++;
      if (bus.CSR_RVALID_OP !== 1'b1 || bus.CSR_ILLEGAL_OP !== 1'b1 || bus.CSR_RDATA_OP !== 32'd0) begin
        failures++;
        $display("FAIL illegal_%h got v=%b i=%b d=%h want v=1 i=1 d=0", addrs[i],
                 bus.CSR_RVALID_OP, bus.CSR_ILLEGAL_OP, bus.CSR_RDATA_OP);
      end
    end
    drive(1, 0, 12'hC02, 0); step();
    checks++;
    if (bus.CSR_RDATA_OP !== 32'hFFFF_FFFF || bus.CSR_ILLEGAL_OP !== 1'b0) begin
      failures++; $display("FAIL illegal_nochange got %h want ffffffff", bus.CSR_RDATA_OP);
    end
    drive(0, 0, 12'h000, 0);
  endtask

  task automatic test_timer();
    drive(0, 1, 12'hB80, 0); step();
    drive(0, 1, 12'h7C1, 0); step();
    drive(0, 1, 12'h7C0, 32'd100); COUNTER_IP = 32'd90; step();
    drive(0, 0, 12'h000, 0);
    for (int c = 95; c <= 100; c++) begin
      COUNTER_IP = c; step();
      if (c >= 99) begin
        checks++;
        if (irq !== (c == 100)) begin failures++; $display("FAIL timer_rise_%0d got %b want %b", c, irq, (c == 100)); end
      end
    end
    COUNTER_IP = 101; drive(0, 1, 12'h7C0, 32'hFFFF_FFFF); step();
    COUNTER_IP = 102; drive(0, 1, 12'h7C1, 32'hFFFF_FFFF); step();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL timer_fall got %b want 0", irq); end
    drive(0, 0, 12'h000, 0);
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 12'h7C1, 0); step();
    drive(0, 1, 12'h7C0, 0); step();
    drive(0, 1, 12'hB02, 32'd7); step();
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL pre_reset_irq got %b want 1", irq); end
    drive(1, 0, 12'hB02, 0);
    #2 RSTN_IP = 0;
    @(posedge CLK_IP); #1;
    checks += 3;
    if (bus.CSR_RVALID_OP !== 1'b0) begin failures++; $display("FAIL midreset_rvalid got %b want 0", bus.CSR_RVALID_OP); end
    if (irq !== 1'b0) begin failures++; $display("FAIL midreset_irq got %b want 0", irq); end
    if (bus.CSR_RDATA_OP !== 32'd0) begin failures++; $display("FAIL midreset_rdata got %h want 0", bus.CSR_RDATA_OP); end
    RSTN_IP = 1;
    model_reset();
    drive(1, 0, 12'hB02, 0); step();
    checks++;
    if (bus.CSR_RDATA_OP !== 32'd0) begin failures++; $display("FAIL postreset_minstret got %h want 0", bus.CSR_RDATA_OP); end
    drive(1, 0, 12'h7C0, 0); step();
    checks++;
    if (bus.CSR_RDATA_OP !== 32'hFFFF_FFFF) begin failures++; $display("FAIL postreset_cmp got %h want ffffffff", bus.CSR_RDATA_OP); end
    drive(1, 0, 12'h7C1, 0); step();
    checks++;
    if (bus.CSR_RDATA_OP !== 32'hFFFF_FFFF) begin failures++; $display("FAIL postreset_cmph got %h want ffffffff", bus.CSR_RDATA_OP); end
    drive(0, 0, 12'h000, 0);
  endtask

  task automatic test_random();
    logic [11:0] pool [12];
    pool[0] = 12'hC00; pool[1] = 12'hC80; pool[2]  = 12'hC02; pool[3]  = 12'hC82;
    pool[4] = 12'hB00; pool[5] = 12'hB80; pool[6]  = 12'hB02; pool[7]  = 12'hB82;
    pool[8] = 12'h320; pool[9] = 12'h7C0; pool[10] = 12'h7C1; pool[11] = 12'h3A5;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 40) == 0) COUNTER_IP = 32'hFFFF_FFFF - $urandom_range(0, 6);
      else COUNTER_IP = COUNTER_IP + $urandom_range(0, 3);
      RETIRE_IP = $urandom_range(0, 1);
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
            pool[$urandom_range(0, 11)],
            ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom);
      step();
      checks += 3;
      if (bus.CSR_RVALID_OP !== exp_rvalid) begin failures++; $display("FAIL rnd_rvalid n=%0d got %b want %b", n, bus.CSR_RVALID_OP, exp_rvalid); end
      if (bus.CSR_RDATA_OP !== exp_rdata) begin failures++; $display("FAIL rnd_rdata n=%0d got %h want %h", n, bus.CSR_RDATA_OP, exp_rdata); end
      if (irq !== exp_irq) begin failures++; $display("FAIL rnd_irq n=%0d got %b want %b", n, irq, exp_irq); end
      if (exp_rvalid) begin
        checks++;
        if (bus.CSR_ILLEGAL_OP !== exp_ill) begin failures++; $display("FAIL rnd_illegal n=%0d got %b want %b", n, bus.CSR_ILLEGAL_OP, exp_ill); end
      end
    end
    drive(0, 0, 12'h000, 0);
    RETIRE_IP = 0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_instret();
    test_illegal();
    test_timer();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
